// File: rtl/game_pkg.sv
// Shared definitions for the game row blocks: controller state encoding and
// shift direction values.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for an already-debounced button level.
// The pulse is combinational off the previous-cycle sample.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic levelQ;

  always_ff @(posedge clk) begin
    if (rst) levelQ <= 1'b0;
    else     levelQ <= level;
  end

  assign rise = level & ~levelQ;

endmodule

// File: rtl/bounce_row_shifter.sv
// Bouncing row shifter: moves a WIDTH-cell pattern end to end on divided step
// pulses, and freezes it on a stop-button rising edge, reporting the locked row.
module bounce_row_shifter
  import game_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SPEED_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_pattern,
  input  logic               step,
  input  logic [SPEED_W-1:0] speed,
  input  logic               stop_btn,
  output logic [WIDTH-1:0]   row_out,
  output logic               moving,
  output logic               dir_out,
  output logic               locked_pulse,
  output logic [WIDTH-1:0]   locked_row
);

  state_t             state;
  logic [WIDTH-1:0]   rowQ;
  logic [WIDTH-1:0]   lockedRowQ;
  logic               dirQ;
  logic               lockedPulseQ;
  logic [SPEED_W-1:0] countQ;
  logic               stopEdge;
  logic [WIDTH-1:0]   nextRow;
  logic               nextDir;

  rise_detect stopDetect (
    .clk  (clk),
    .rst  (rst),
    .level(stop_btn),
    .rise (stopEdge)
  );

  // The bounce happens within the move: when the leading edge cell is occupied
  // the direction flips and the row shifts the other way. If both end cells are
  // occupied (full row) the row holds and keeps its direction.
  always_comb begin
    nextRow = rowQ;
    nextDir = dirQ;
    if (dirQ == DIR_LSB) begin
      if (!rowQ[0]) begin
        nextRow = rowQ >> 1;
      end else if (!rowQ[WIDTH-1]) begin
        nextRow = rowQ << 1;
        nextDir = DIR_MSB;
      end
    end else begin
      if (!rowQ[WIDTH-1]) begin
        nextRow = rowQ << 1;
      end else if (!rowQ[0]) begin
        nextRow = rowQ >> 1;
        nextDir = DIR_LSB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rowQ         <= '0;
      lockedRowQ   <= '0;
      dirQ         <= DIR_LSB;
      lockedPulseQ <= 1'b0;
      countQ       <= '0;
    end else begin
      lockedPulseQ <= 1'b0;
      if (load) begin
        rowQ   <= load_pattern;
        dirQ   <= DIR_LSB;
        countQ <= '0;
        state  <= (load_pattern == '0) ? ST_IDLE : ST_MOVE;
      end else begin
        unique case (state)
          ST_MOVE: begin
            if (stopEdge) begin
              state        <= ST_LOCKED;
              lockedRowQ   <= rowQ;
              lockedPulseQ <= 1'b1;
            end else if (step) begin
              // >= lets a lowered speed take effect on the very next step
              if (countQ >= speed) begin
                rowQ   <= nextRow;
                dirQ   <= nextDir;
                countQ <= '0;
              end else begin
                countQ <= countQ + 1'b1;
              end
            end
          end
          ST_IDLE, ST_LOCKED: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign row_out      = rowQ;
  assign locked_row   = lockedRowQ;
  assign locked_pulse = lockedPulseQ;
  assign dir_out      = dirQ;
  assign moving       = (state == ST_MOVE);

endmodule

// File: doc/bounce_row_shifter.md
Name: bounce_row_shifter

Overview:
- Parametrised successor to the 8-bit game block shifter: holds a row pattern of WIDTH cells and bounces it end to end.
- Advances on an external step pulse, divided by a run-time speed setting.
- Freezes the row on a stop-button press and reports the locked row with a one-cycle pulse.
- Sits between the game controller, which loads patterns and reads locked rows, and the display row driver, which reads row_out.

Parameters:
WIDTH, 8, number of cells in the row (minimum 2)
SPEED_W, 4, width of the speed divider setting and its counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
load  in  1  one-cycle strobe: capture load_pattern and start moving
load_pattern  in  WIDTH  initial row pattern (contiguous block expected, not checked)
step  in  1  one-cycle movement tick (the adjusted clock pulse, used as an enable)
speed  in  SPEED_W  step pulses per move minus 1 (0 = move on every step)
stop_btn  in  1  stop button level, already debounced; rising edge is detected internally
row_out  out  WIDTH  current row pattern
moving  out  1  high while in MOVE
dir_out  out  1  current direction: 0 = toward LSB, 1 = toward MSB
locked_pulse  out  1  one-cycle pulse on entry to LOCKED
locked_row  out  WIDTH  row captured at lock; holds until the next lock or reset

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - row_out=0, locked_row=0, state=IDLE, dir=0, divider count=0.
  - locked_pulse=0, moving=0, stop edge register=0.
- States:
  - IDLE: row_out is held.
  - MOVE: row shifts on divided ticks.
  - LOCKED: row is frozen.
- load (any state, highest priority after rst):
  - row_out<=load_pattern, dir<=0, count<=0.
  - Next state is MOVE, unless load_pattern==0, in which case next state is IDLE and row_out=0.
  - A stop edge in the same cycle is ignored.
- Stop edge: stop_edge = stop_btn & ~stop_q, where stop_q is registered every cycle.
  - In MOVE, a stop edge with no load: next state LOCKED, locked_row<=row_out, locked_pulse=1 for exactly one cycle.
  - The stop edge wins over a coincident step, so no shift happens that cycle.
  - In IDLE and LOCKED, stop edges are ignored.
  - A button still held across a load does not lock; a fresh rising edge is required.
- Divider (MOVE only, on step=1):
  - If count >= speed: perform a move and set count<=0.
  - Otherwise count<=count+1.
  - The >= compare makes a mid-run decrease of speed take effect on the next step.
  - Without step, count holds.
- Move rule (dir 0):
  - If row_out[0]==0, shift right by 1.
  - Otherwise set dir<=1 and shift left by 1 in the same move. There is no dwell move at the edge.
- Move rule (dir 1): mirror image, using row_out[WIDTH-1].
- Full row (row_out all ones): a move leaves row_out unchanged and keeps dir. No bits are ever lost or wrapped around.
- Latency:
  - row_out updates on the clock edge that samples the qualifying step.
  - locked_row and locked_pulse are registered, appearing one edge after the stop edge is sampled.
- LOCKED exits only via load or rst.
- Reset mid-move or mid-lock: everything returns to reset values on that edge.
- Output decodes: moving = (state==MOVE); dir_out = dir.

Decomposition:
- Shared package (game_pkg):
  - State encoding constants ST_IDLE, ST_MOVE, ST_LOCKED.
  - Direction constants DIR_LSB=0, DIR_MSB=1.
- Sub-module rise_detect: a 1-bit registered rising-edge detector, reused for the stop button and other game buttons.
- The remainder (FSM, divider, shifter) stays in one module.

Test Plan (WIDTH=8):
1. load 8'b00011000, speed=0, 6 step pulses -> row_out: 00001100, 00000110, 00000011, 00000110, 00001100, 00011000; dir_out 0 until the 4th move, then 1.
2. speed=2, load 8'b11000000, 9 steps -> only steps 3, 6 and 9 move the row: 01100000, 00110000, 00011000; count returns to 0 after each move.
3. From test 1, stop_btn rises in the same cycle as a step while row_out=00000110 -> no shift; locked_pulse high 1 cycle; locked_row=00000110; further steps leave row_out unchanged.
4. Hold stop_btn high, then load 8'b00111000 -> state MOVE, no lock; releasing and pressing again -> lock.
5. Load 8'hFF and step ×3 -> row_out stays FF, dir_out stays 0; load 8'h00 -> moving=0, row_out=0.
6. Assert rst mid-move with row_out=00001100, count=1 -> next edge: row_out=0, locked_row=0, moving=0, dir_out=0; steps afterwards have no effect until load.
